// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding, button indices and event priority for stopwatch_ctrl
package stopwatch_pkg;

  // Controller states; the encoding is exported on state_o for debug LEDs.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DONE  = 3'd3,
    S_ADJ   = 3'd4
  } state_t;

  localparam int NUM_BTN   = 7;
  localparam int BTN_IDX_W = 3;

  // Bit positions of each button inside the packed button/event vectors.
  localparam logic [BTN_IDX_W-1:0] BTN_CLEAR = 3'd0;
  localparam logic [BTN_IDX_W-1:0] BTN_START = 3'd1;
  localparam logic [BTN_IDX_W-1:0] BTN_REV   = 3'd2;
  localparam logic [BTN_IDX_W-1:0] BTN_ADD   = 3'd3;
  localparam logic [BTN_IDX_W-1:0] BTN_SUB   = 3'd4;
  localparam logic [BTN_IDX_W-1:0] BTN_FAST  = 3'd5;
  localparam logic [BTN_IDX_W-1:0] BTN_SLOW  = 3'd6;

  // Acceptance order: PRIO[0] is the most important button.
  localparam logic [NUM_BTN-1:0][BTN_IDX_W-1:0] PRIO =
    {BTN_SLOW, BTN_FAST, BTN_SUB, BTN_ADD, BTN_REV, BTN_START, BTN_CLEAR};

  // Returns a one-hot vector holding only the highest-priority pending event.
  function automatic logic [NUM_BTN-1:0] prio_pick(input logic [NUM_BTN-1:0] ev);
    logic [NUM_BTN-1:0]   pick;
    logic [BTN_IDX_W-1:0] idx;
    pick = '0;
    for (int p = NUM_BTN - 1; p >= 0; p--) begin
      idx = PRIO[p[BTN_IDX_W-1:0]];
      if (ev[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - front-panel buttons and datapath control bundle for stopwatch_ctrl
interface stopwatch_ctrl_if #(
  parameter int SPD_W = 2
);
  logic             btn_start_i;
  logic             btn_rev_i;
  logic             btn_clear_i;
  logic             btn_add_i;
  logic             btn_sub_i;
  logic             btn_fast_i;
  logic             btn_slow_i;
  logic             limit_hit_i;
  logic             run_o;
  logic             reverse_o;
  logic             clear_o;
  logic             add_o;
  logic             sub_o;
  logic [SPD_W-1:0] speed_o;
  logic [2:0]       state_o;

  // Panel and datapath side: presses buttons, reports the terminal compare.
  modport master (
    output btn_start_i, btn_rev_i, btn_clear_i, btn_add_i, btn_sub_i,
           btn_fast_i, btn_slow_i, limit_hit_i,
    input  run_o, reverse_o, clear_o, add_o, sub_o, speed_o, state_o
  );

  // Controller side.
  modport slave (
    input  btn_start_i, btn_rev_i, btn_clear_i, btn_add_i, btn_sub_i,
           btn_fast_i, btn_slow_i, limit_hit_i,
    output run_o, reverse_o, clear_o, add_o, sub_o, speed_o, state_o
  );
endinterface

// File: rtl/stopwatch_ctrl_btn_conditioner.sv
// rtl/stopwatch_ctrl_btn_conditioner.sv - optional debounce (STOPWATCH_DEBOUNCE_EN) and rising-edge detect for the button vector
module btn_conditioner #(
  parameter int W = 7
`ifdef STOPWATCH_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYC = 16
`endif
) (
  input  logic         clk_in,
  input  logic         RESET,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] w_level;
  logic [W-1:0] r_prev;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [W-1:0][CNT_W-1:0] r_cnt;
  logic [W-1:0]            r_stable;

  // Per-button filter: a new level is adopted only after DEBOUNCE_CYC consecutive agreeing samples.
  always_ff @(posedge clk_in) begin
    if (RESET) begin
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (i_raw[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
          r_stable[i] <= i_raw[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_level = r_stable;
`else
  assign w_level = i_raw;
`endif

  // Previous-level register; a held button produces a single rise.
  always_ff @(posedge clk_in) begin
    if (RESET) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_rise = w_level & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch front-panel controller: button arbitration and run/pause/done FSM (debounce via STOPWATCH_DEBOUNCE_EN)
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int SPD_W         = 2,
  parameter int SPEED_DEFAULT = 1,
  parameter int SPEED_MAX     = 3,
  parameter int DEBOUNCE_CYC  = 16
) (
  input logic             clk_in,
  input logic             RESET,
  stopwatch_ctrl_if.slave bus
);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_ev;
  logic [NUM_BTN-1:0] w_win;

  state_t             r_state;
  state_t             r_ret;
  logic               r_run;
  logic               r_rev;
  logic               r_clear;
  logic               r_add;
  logic               r_sub;
  logic [SPD_W-1:0]   r_speed;

  assign w_raw = {bus.btn_slow_i, bus.btn_fast_i, bus.btn_sub_i, bus.btn_add_i,
                  bus.btn_rev_i, bus.btn_start_i, bus.btn_clear_i};

  btn_conditioner #(
    .W            (NUM_BTN)
`ifdef STOPWATCH_DEBOUNCE_EN
    ,
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
`endif
  ) u_btn_cond (
    .clk_in (clk_in),
    .RESET  (RESET),
    .i_raw  (w_raw),
    .o_rise (w_ev)
  );

  // Only the highest-priority event of a cycle survives; the rest are dropped.
  assign w_win = prio_pick(w_ev);

  // Controller FSM with registered outputs; pulses last exactly one cycle.
  always_ff @(posedge clk_in) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_ret   <= S_IDLE;
      r_run   <= 1'b0;
      r_rev   <= 1'b0;
      r_clear <= 1'b0;
      r_add   <= 1'b0;
      r_sub   <= 1'b0;
      r_speed <= SPD_W'(SPEED_DEFAULT);
    end else begin
      r_clear <= 1'b0;
      r_add   <= 1'b0;
      r_sub   <= 1'b0;
      if (r_state == S_ADJ) begin
        // Adjust lasts one cycle and ignores every button while it is active.
        r_state <= r_ret;
        r_run   <= 1'b0;
      end else if (w_win[BTN_CLEAR]) begin
        r_clear <= 1'b1;
        r_state <= S_IDLE;
        r_run   <= 1'b0;
      end else if ((r_state == S_RUN) && bus.limit_hit_i) begin
        r_state <= S_DONE;
        r_run   <= 1'b0;
      end else if (w_win[BTN_START]) begin
        if ((r_state == S_IDLE) || (r_state == S_PAUSE)) begin
          r_state <= S_RUN;
          r_run   <= 1'b1;
        end else if (r_state == S_RUN) begin
          r_state <= S_PAUSE;
          r_run   <= 1'b0;
        end
      end else if (w_win[BTN_REV]) begin
        if (r_state != S_RUN) begin
          r_rev <= ~r_rev;
        end
        if (r_state == S_DONE) begin
          r_state <= S_PAUSE;
        end
      end else if (w_win[BTN_ADD] || w_win[BTN_SUB]) begin
        if (r_state != S_RUN) begin
          r_state <= S_ADJ;
          r_ret   <= (r_state == S_IDLE) ? S_IDLE : S_PAUSE;
          r_add   <= w_win[BTN_ADD];
          r_sub   <= w_win[BTN_SUB];
        end
      end else if (w_win[BTN_FAST]) begin
        if (r_speed < SPD_W'(SPEED_MAX)) begin
          r_speed <= r_speed + 1'b1;
        end
      end else if (w_win[BTN_SLOW]) begin
        if (r_speed != '0) begin
          r_speed <= r_speed - 1'b1;
        end
      end
    end
  end

  assign bus.run_o     = r_run;
  assign bus.reverse_o = r_rev;
  assign bus.clear_o   = r_clear;
  assign bus.add_o     = r_add;
  assign bus.sub_o     = r_sub;
  assign bus.speed_o   = r_speed;
  assign bus.state_o   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

  localparam logic [6:0] B_NONE  = 7'h00;
  localparam logic [6:0] B_CLEAR = 7'h01;
  localparam logic [6:0] B_START = 7'h02;
  localparam logic [6:0] B_REV   = 7'h04;
  localparam logic [6:0] B_ADD   = 7'h08;
  localparam logic [6:0] B_SUB   = 7'h10;
  localparam logic [6:0] B_FAST  = 7'h20;
  localparam logic [6:0] B_SLOW  = 7'h40;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stopwatch_ctrl_if #(.SPD_W(2)) sw_if ();

  stopwatch_ctrl #(
    .SPD_W         (2),
    .SPEED_DEFAULT (1),
    .SPEED_MAX     (3),
    .DEBOUNCE_CYC  (16)
  ) dut (
    .clk_in (clk),
    .RESET  (rst),
    .bus    (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input logic [6:0] m);
    sw_if.btn_clear_i = m[0];
    sw_if.btn_start_i = m[1];
    sw_if.btn_rev_i   = m[2];
    sw_if.btn_add_i   = m[3];
    sw_if.btn_sub_i   = m[4];
    sw_if.btn_fast_i  = m[5];
    sw_if.btn_slow_i  = m[6];
  endtask

  // One-cycle press; outputs seen on return are the response to that press.
  task automatic pulse(input logic [6:0] m);
    drive(m);
    step();
    drive(B_NONE);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw_if.limit_hit_i = 1'b0;
    drive(B_NONE);
    idle(2);
    checks++; if (sw_if.state_o !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", sw_if.state_o); end
    checks++; if ({sw_if.run_o, sw_if.reverse_o, sw_if.clear_o, sw_if.add_o, sw_if.sub_o} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=00000", {sw_if.run_o, sw_if.reverse_o, sw_if.clear_o, sw_if.add_o, sw_if.sub_o}); end
    checks++; if (sw_if.speed_o !== 2'd1) begin errors++; $display("FAIL reset_speed got=%0d exp=1", sw_if.speed_o); end
    // An add press in the reset cycle must not emit a pulse.
    drive(B_ADD);
    step();
    checks++; if (sw_if.add_o !== 1'b0 || sw_if.state_o !== 3'd0) begin
      errors++; $display("FAIL reset_abort add_o=%b state=%0d exp add_o=0 state=0", sw_if.add_o, sw_if.state_o); end
    drive(B_NONE);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_start_pause();
    pulse(B_START);
    checks++; if (sw_if.run_o !== 1'b1 || sw_if.state_o !== 3'd1) begin
      errors++; $display("FAIL start_run run=%b state=%0d exp run=1 state=1", sw_if.run_o, sw_if.state_o); end
    idle(1);
    checks++; if (sw_if.state_o !== 3'd1) begin errors++; $display("FAIL start_hold state=%0d exp=1", sw_if.state_o); end
    pulse(B_START);
    checks++; if (sw_if.run_o !== 1'b0 || sw_if.state_o !== 3'd2) begin
      errors++; $display("FAIL start_pause run=%b state=%0d exp run=0 state=2", sw_if.run_o, sw_if.state_o); end
    idle(1);
  endtask

  task automatic test_limit();
    pulse(B_START);
    idle(1);
    sw_if.limit_hit_i = 1'b1;
    step();
    sw_if.limit_hit_i = 1'b0;
    checks++; if (sw_if.run_o !== 1'b0 || sw_if.state_o !== 3'd3) begin
      errors++; $display("FAIL limit_done run=%b state=%0d exp run=0 state=3", sw_if.run_o, sw_if.state_o); end
    pulse(B_START);
    checks++; if (sw_if.run_o !== 1'b0 || sw_if.state_o !== 3'd3) begin
      errors++; $display("FAIL done_start_ignored run=%b state=%0d exp run=0 state=3", sw_if.run_o, sw_if.state_o); end
    idle(1);
    pulse(B_REV);
    checks++; if (sw_if.reverse_o !== 1'b1 || sw_if.state_o !== 3'd2) begin
      errors++; $display("FAIL done_rev rev=%b state=%0d exp rev=1 state=2", sw_if.reverse_o, sw_if.state_o); end
    idle(1);
  endtask

  task automatic test_adjust();
    pulse(B_ADD | B_SUB);
    checks++; if (sw_if.add_o !== 1'b1 || sw_if.sub_o !== 1'b0 || sw_if.state_o !== 3'd4) begin
      errors++; $display("FAIL adj_add add=%b sub=%b state=%0d exp add=1 sub=0 state=4", sw_if.add_o, sw_if.sub_o, sw_if.state_o); end
    step();
    checks++; if (sw_if.add_o !== 1'b0 || sw_if.state_o !== 3'd2) begin
      errors++; $display("FAIL adj_return add=%b state=%0d exp add=0 state=2", sw_if.add_o, sw_if.state_o); end
    pulse(B_SUB);
    checks++; if (sw_if.sub_o !== 1'b1 || sw_if.add_o !== 1'b0 || sw_if.state_o !== 3'd4) begin
      errors++; $display("FAIL adj_sub sub=%b add=%b state=%0d exp sub=1 add=0 state=4", sw_if.sub_o, sw_if.add_o, sw_if.state_o); end
    step();
    checks++; if (sw_if.sub_o !== 1'b0 || sw_if.state_o !== 3'd2) begin
      errors++; $display("FAIL adj_sub_return sub=%b state=%0d exp sub=0 state=2", sw_if.sub_o, sw_if.state_o); end
  endtask

  task automatic test_clear();
    pulse(B_START);
    idle(1);
    pulse(B_CLEAR | B_START);
    checks++; if (sw_if.clear_o !== 1'b1 || sw_if.state_o !== 3'd0 || sw_if.run_o !== 1'b0) begin
      errors++; $display("FAIL clear_win clear=%b state=%0d run=%b exp clear=1 state=0 run=0", sw_if.clear_o, sw_if.state_o, sw_if.run_o); end
    checks++; if (sw_if.reverse_o !== 1'b1) begin errors++; $display("FAIL clear_keeps_rev got=%b exp=1", sw_if.reverse_o); end
    step();
    checks++; if (sw_if.clear_o !== 1'b0) begin errors++; $display("FAIL clear_one_cycle got=%b exp=0", sw_if.clear_o); end
  endtask

  task automatic test_run_ignores();
    pulse(B_START);
    idle(1);
    pulse(B_REV);
    checks++; if (sw_if.reverse_o !== 1'b1 || sw_if.state_o !== 3'd1) begin
      errors++; $display("FAIL run_rev_ignored rev=%b state=%0d exp rev=1 state=1", sw_if.reverse_o, sw_if.state_o); end
    idle(1);
    pulse(B_ADD);
    checks++; if (sw_if.add_o !== 1'b0 || sw_if.state_o !== 3'd1) begin
      errors++; $display("FAIL run_add_ignored add=%b state=%0d exp add=0 state=1", sw_if.add_o, sw_if.state_o); end
    idle(1);
    sw_if.limit_hit_i = 1'b1;
    pulse(B_START);
    sw_if.limit_hit_i = 1'b0;
    checks++; if (sw_if.state_o !== 3'd3) begin errors++; $display("FAIL limit_beats_start state=%0d exp=3", sw_if.state_o); end
    idle(1);
    pulse(B_CLEAR);
    idle(1);
  endtask

  task automatic test_limit_on_entry();
    sw_if.limit_hit_i = 1'b1;
    step();
    checks++; if (sw_if.state_o !== 3'd0) begin errors++; $display("FAIL idle_limit_ignored state=%0d exp=0", sw_if.state_o); end
    pulse(B_START);
    checks++; if (sw_if.run_o !== 1'b1 || sw_if.state_o !== 3'd1) begin
      errors++; $display("FAIL entry_run run=%b state=%0d exp run=1 state=1", sw_if.run_o, sw_if.state_o); end
    step();
    checks++; if (sw_if.run_o !== 1'b0 || sw_if.state_o !== 3'd3) begin
      errors++; $display("FAIL entry_done run=%b state=%0d exp run=0 state=3", sw_if.run_o, sw_if.state_o); end
    sw_if.limit_hit_i = 1'b0;
    pulse(B_CLEAR);
    idle(1);
  endtask

  task automatic test_priority();
    pulse(B_REV | B_ADD);
    checks++; if (sw_if.reverse_o !== 1'b0 || sw_if.state_o !== 3'd0 || sw_if.add_o !== 1'b0) begin
      errors++; $display("FAIL prio_rev_over_add rev=%b state=%0d add=%b exp rev=0 state=0 add=0", sw_if.reverse_o, sw_if.state_o, sw_if.add_o); end
    idle(1);
  endtask

  task automatic test_speed();
    logic [1:0] exp_up [5];
    logic [1:0] exp_dn [5];
    exp_up = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    exp_dn = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
    for (int i = 0; i < 5; i++) begin
      pulse(B_FAST);
      checks++; if (sw_if.speed_o !== exp_up[i]) begin errors++; $display("FAIL speed_up[%0d] got=%0d exp=%0d", i, sw_if.speed_o, exp_up[i]); end
      idle(1);
    end
    for (int i = 0; i < 5; i++) begin
      pulse(B_SLOW);
      checks++; if (sw_if.speed_o !== exp_dn[i]) begin errors++; $display("FAIL speed_down[%0d] got=%0d exp=%0d", i, sw_if.speed_o, exp_dn[i]); end
      idle(1);
    end
    drive(B_FAST);
    idle(10);
    checks++; if (sw_if.speed_o !== 2'd1) begin errors++; $display("FAIL speed_hold got=%0d exp=1", sw_if.speed_o); end
    checks++; if (sw_if.state_o !== 3'd0) begin errors++; $display("FAIL speed_no_state_change got=%0d exp=0", sw_if.state_o); end
    drive(B_NONE);
    idle(1);
  endtask

`ifdef STOPWATCH_DEBOUNCE_EN
  task automatic test_debounce();
    drive(B_START);
    idle(15);
    drive(B_NONE);
    idle(20);
    checks++; if (sw_if.state_o !== 3'd0) begin errors++; $display("FAIL debounce_glitch state=%0d exp=0", sw_if.state_o); end
    drive(B_START);
    idle(16);
    checks++; if (sw_if.state_o !== 3'd0) begin errors++; $display("FAIL debounce_early state=%0d exp=0", sw_if.state_o); end
    step();
    checks++; if (sw_if.state_o !== 3'd1) begin errors++; $display("FAIL debounce_event state=%0d exp=1", sw_if.state_o); end
    drive(B_NONE);
    idle(20);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
`ifdef STOPWATCH_DEBOUNCE_EN
    test_debounce();
`else
    test_start_pause();
    test_limit();
    test_adjust();
    test_clear();
    test_run_ignores();
    test_limit_on_entry();
    test_priority();
    test_speed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
